// File: rtl/arb2_sel.sv
// Two-requester round-robin arbiter driving the select of a downstream 2:1 mux.
// Optional forced-release timer is enabled by defining ARB2_SEL_TIMEOUT_EN.
module arb2_sel #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic done,
  output logic sel,
  output logic gnt0,
  output logic gnt1,
  output logic busy,
  output logic timeout
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   sel_q, sel_d;
  logic   gnt0_q, gnt0_d;
  logic   gnt1_q, gnt1_d;
  logic   busy_q, busy_d;

`ifdef ARB2_SEL_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       to_q, to_d;
  logic       expire;

  // cnt_q holds the number of grant cycles already completed, so the
  // TIMEOUT_CYC-th held cycle is the last one.
  assign expire = (cnt_q == 8'(TIMEOUT_CYC - 1));
  assign cnt_d  = (state_q != IDLE && state_d == state_q) ? cnt_q + 8'd1 : 8'd0;
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  // State register; outputs are registered from next-state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef ARB2_SEL_TIMEOUT_EN
      cnt_q   <= 8'd0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      busy_q  <= busy_d;
`ifdef ARB2_SEL_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
`ifdef ARB2_SEL_TIMEOUT_EN
    to_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = last_q ? GNT0 : GNT1;
        else if (req0)     state_d = GNT0;
        else if (req1)     state_d = GNT1;
      end
      GNT0: begin
        if (done || !req0) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
`ifdef ARB2_SEL_TIMEOUT_EN
        else if (expire) begin
          state_d = IDLE;
          last_d  = 1'b0;
          to_d    = 1'b1;
        end
`endif
      end
      GNT1: begin
        if (done || !req1) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
`ifdef ARB2_SEL_TIMEOUT_EN
        else if (expire) begin
          state_d = IDLE;
          last_d  = 1'b1;
          to_d    = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode; sel keeps its value through IDLE so the mux stays quiet.
  always_comb begin
    gnt0_d = (state_d == GNT0);
    gnt1_d = (state_d == GNT1);
    busy_d = gnt0_d | gnt1_d;
    sel_d  = sel_q;
    if (gnt0_d)      sel_d = 1'b0;
    else if (gnt1_d) sel_d = 1'b1;
  end

  assign sel  = sel_q;
  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_arb2_sel.sv
// Directed bench for arb2_sel: expected outputs are queued per step and
// compared after the following clock edge.
module tb_arb2_sel;

`ifdef ARB2_SEL_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic clk = 1'b0;
  logic rst, req0, req1, done;
  logic sel, gnt0, gnt1, busy, timeout;

  typedef struct {
    string      tag;
    logic [4:0] v;   // {sel, gnt0, gnt1, busy, timeout}
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  arb2_sel #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .done(done),
    .sel(sel), .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] E_IDLE0 = 5'b00000;
  localparam logic [4:0] E_IDLE1 = 5'b10000;
  localparam logic [4:0] E_G0    = 5'b01010;
  localparam logic [4:0] E_G1    = 5'b10110;
  localparam logic [4:0] E_TO0   = 5'b00001;

  task automatic push(input string tag, input logic [4:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t       e;
    logic [4:0] obs;
    e   = sb.pop_front();
    obs = {sel, gnt0, gnt1, busy, timeout};
    checks++;
    assert (obs === e.v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
    end
  endtask

  // Drive inputs, queue the expected post-edge outputs, sample 1 time unit after the edge.
  task automatic step(input logic r0, input logic r1, input logic d,
                      input string tag, input logic [4:0] v);
    req0 = r0; req1 = r1; done = d;
    push(tag, v);
    @(posedge clk);
    #1;
    check_now();
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; done = 1'b0;
    #1;
    push("reset_async", E_IDLE0);
    check_now();
    @(posedge clk); #1;
    push("reset_held", E_IDLE0);
    check_now();
    rst = 1'b0;
    step(0, 0, 0, "idle_noreq", E_IDLE0);
    step(0, 0, 1, "idle_done_ignored", E_IDLE0);

    // Single requester 1, released by done after four held cycles
    step(0, 1, 0, "g1_c1", E_G1);
    step(0, 1, 0, "g1_c2", E_G1);
    step(1, 1, 0, "g1_ignore_req0", E_G1);
    step(0, 1, 0, "g1_c4", E_G1);
    step(0, 1, 1, "g1_done_sel_hold", E_IDLE1);
    step(0, 0, 0, "idle_sel_hold", E_IDLE1);

    // Both requesting: alternate with one IDLE cycle between grants
    step(1, 1, 0, "rr_g0_a", E_G0);
    step(1, 1, 1, "rr_idle_a", E_IDLE0);
    step(1, 1, 0, "rr_g1_a", E_G1);
    step(1, 1, 1, "rr_idle_b", E_IDLE1);
    step(1, 1, 0, "rr_g0_b", E_G0);
    step(1, 1, 1, "rr_idle_c", E_IDLE0);
    step(1, 1, 0, "rr_g1_b", E_G1);
    step(1, 1, 1, "rr_idle_d", E_IDLE1);

    // Release by dropping the request
    step(1, 0, 0, "g0_req", E_G0);
    step(0, 1, 0, "g0_req_drop", E_IDLE0);
    step(0, 1, 0, "g1_after_drop", E_G1);
    step(0, 0, 0, "g1_req_drop", E_IDLE1);

    // Asynchronous reset in the middle of a grant
    step(1, 0, 0, "pre_rst_g0", E_G0);
    #1 rst = 1'b1;
    #1;
    push("rst_mid_grant", E_IDLE0);
    check_now();
    @(posedge clk); #1;
    rst = 1'b0;
    step(0, 1, 0, "post_rst_g1", E_G1);
    step(0, 1, 1, "post_rst_rel", E_IDLE1);

`ifdef ARB2_SEL_TIMEOUT_EN
    step(1, 0, 0, "to_g0_c1", E_G0);
    step(1, 0, 0, "to_g0_c2", E_G0);
    step(1, 0, 0, "to_g0_c3", E_G0);
    step(1, 0, 0, "to_g0_c4", E_G0);
    step(1, 0, 0, "to_pulse", E_TO0);
    step(1, 0, 0, "to_regrant", E_G0);
    step(1, 0, 0, "to2_c2", E_G0);
    step(1, 0, 0, "to2_c3", E_G0);
    step(1, 0, 0, "to2_c4", E_G0);
    step(1, 0, 1, "to_done_coincide", E_IDLE0);
    step(0, 0, 0, "to_quiet", E_IDLE0);
`else
    for (int i = 0; i < 300; i++) step(1, 0, 0, "hold_g0", E_G0);
    step(1, 0, 1, "hold_release", E_IDLE0);
    step(0, 0, 0, "hold_quiet", E_IDLE0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
